irq_ctrl_wb: RTL
================

# irq_ctrl_wb

Wishbone-attached interrupt/event controller that consumes event flags from SoC peripherals (timer `ev`, ledstring done, button edges) and produces a single registered CPU interrupt line. It latches per-source pending bits, masks them with an enable register, and reports the highest-priority pending source through a claim register. It sits on the same peripheral bus as the timer, directly downstream of the timer's event output.

## Interface
- `N_SRC`, default 8: number of event sources, 1..32.
- `clk` input 1: system clock.
- `rst` input 1: reset, synchronous, active-high.
- `wb_addr` input 3: register select, word index.
- `wb_rdata` output 32: read data, valid while `wb_ack`=1, 0 otherwise.
- `wb_wdata` input 32: write data.
- `wb_we` input 1: write enable.
- `wb_cyc` input 1: cycle/strobe.
- `wb_ack` output 1: single-cycle acknowledge.
- `ev_in` input N_SRC: event inputs, `clk` domain, level-valued.
- `irq` output 1: registered interrupt request to CPU.

## Operation
- Registers (bits ≥ N_SRC read 0, writes to them ignored):
  - 0 STATUS (RO): sampled `ev_q`.
  - 1 ENABLE (RW): per-source mask.
  - 2 PENDING (R/W1C): latched events.
  - 3 CLAIM (RO): [31] valid, [4:0] lowest index i with pending[i]&enable[i]; all-zero when none. A read does not clear anything.
  - 4 MODE (RW, only with macro): 1 = edge, 0 = level.
  - 5..7: read 0, writes ignored.
- `ev_q` <= `ev_in` every cycle; `ev_d` <= `ev_q`.
- Level source: pending set whenever `ev_q`=1.
- Edge source: pending set when `ev_q & ~ev_d`.
- W1C: writing 1 to PENDING bit clears it; a set condition in the same cycle wins, so the bit stays 1.
- `irq` <= |(pending & enable); enable does not gate latching, so masked events are still recorded.
- Reset: ENABLE, PENDING, MODE, `ev_q`, `ev_d`, `irq`, `wb_ack`, `wb_rdata` all 0.
- A source already high when reset is released is seen as a rising edge, because `ev_d` resets to 0.

## Timing
- Ack: `wb_ack` <= `wb_cyc & ~wb_ack`.
  - A held `wb_cyc` yields an ack every other cycle.
  - A transaction completes on the first ack.
- Read data is registered. It is sampled from register state on the cycle before ack and presented with ack.
- Write strobe is registered and asserted in the ack cycle. The register updates at the end of the ack cycle and is visible to a read issued after ack.
- Event latency: `ev_in` high before edge E0 gives `ev_q`=1 after E0, pending=1 after E1, and `irq`=1 after E2.
- Clear latency: a W1C in the ack cycle drops pending after that edge and drops `irq` one edge later.
- ENABLE write: `irq` follows one edge after ENABLE updates.
- CLAIM is computed from current pending/enable, so a read in the same cycle as a pending update returns pre-update state.
- `rst` mid-transaction: ack drops next cycle and no write takes effect.

## Configuration
- `IRQ_CTRL_EDGE_MODE_EN` defined: MODE register is implemented and per-source edge/level selection is available.
- Not defined:
  - MODE does not exist, reads 0, writes are ignored.
  - All sources are level-mode.
  - Edge detector flops (`ev_d`) are removed.

## Structure
- Shared header `irq_ctrl_defs.vh` holds:
  - register address constants `IRQ_REG_STATUS`..`IRQ_REG_MODE`;
  - `IRQ_CLAIM_VALID_BIT` = 31;
  - `IRQ_CLAIM_ID_W` = 5.
- Sub-module `irq_prio_enc`, parameterised by N_SRC: lowest-index-first priority encoder producing {valid, id}, used for CLAIM.
- Bus logic, event sampling and pending/irq logic live in the `irq_ctrl_wb` top.

## Test plan
- Reset, then read all 8 addresses -> all return 0 and `irq`=0. Without macro, addr 4 also reads 0 after writing 0xFF.
- ENABLE=0x01, pulse `ev_in[0]` for 1 cycle (level) -> PENDING=0x01, `irq`=1 two edges after the `ev_q` edge, CLAIM=0x80000000. Write PENDING=0x01 -> PENDING=0, `irq`=0.
- ENABLE=0, `ev_in[3]` pulse -> PENDING=0x08 and `irq`=0. Write ENABLE=0x08 -> `irq`=1 one edge after ENABLE updates.
- `ev_in[2]` held high (level), W1C bit 2 -> PENDING still 0x04 (set wins). Drop `ev_in[2]`, W1C -> 0.
- Macro on: MODE=0x02, hold `ev_in[1]` high for 10 cycles -> pending set once. After W1C it stays 0 while the input remains high. A second rising edge sets it again.
- ENABLE=0xFF, pulse `ev_in[5]` and `ev_in[2]` together -> CLAIM=0x80000002. Clear bit 2 -> CLAIM=0x80000005.

Source files
------------

// File: rtl/irq_ctrl_wb_pkg.sv
// Shared constants for the Wishbone interrupt controller: register map and CLAIM layout.
package irq_ctrl_wb_pkg;

  localparam logic [2:0] IRQ_REG_STATUS  = 3'd0;
  localparam logic [2:0] IRQ_REG_ENABLE  = 3'd1;
  localparam logic [2:0] IRQ_REG_PENDING = 3'd2;
  localparam logic [2:0] IRQ_REG_CLAIM   = 3'd3;
  localparam logic [2:0] IRQ_REG_MODE    = 3'd4;

  localparam int unsigned IRQ_CLAIM_VALID_BIT = 31;
  localparam int unsigned IRQ_CLAIM_ID_W      = 5;

  function automatic logic [31:0] pack_claim(input logic                      valid,
                                             input logic [IRQ_CLAIM_ID_W-1:0] id);
    logic [31:0] word;
    word                      = '0;
    word[IRQ_CLAIM_VALID_BIT] = valid;
    word[IRQ_CLAIM_ID_W-1:0]  = id;
    return word;
  endfunction

endpackage

// File: rtl/irq_ctrl_wb_if.sv
// Wishbone-style register bus between the CPU side (master) and the interrupt controller (slave).
interface irq_ctrl_wb_if;
  logic [2:0]  wb_addr;
  logic [31:0] wb_rdata;
  logic [31:0] wb_wdata;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_ack;

  modport master (
    output wb_addr, wb_wdata, wb_we, wb_cyc,
    input  wb_rdata, wb_ack
  );

  modport slave (
    input  wb_addr, wb_wdata, wb_we, wb_cyc,
    output wb_rdata, wb_ack
  );
endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder; id is 0 when nothing is requested.
module irq_prio_enc
  import irq_ctrl_wb_pkg::*;
#(
  parameter int unsigned N_SRC = 8
) (
  input  logic [N_SRC-1:0]          i_req,
  output logic                      o_valid,
  output logic [IRQ_CLAIM_ID_W-1:0] o_id
);

  // Scan downwards so the lowest set index is the last to assign.
  always_comb begin
    o_valid = 1'b0;
    o_id    = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_valid = 1'b1;
        o_id    = IRQ_CLAIM_ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl_wb.sv
// Event latching interrupt controller on a Wishbone register bus.
// Define IRQ_CTRL_EDGE_MODE_EN to add the MODE register and per-source edge detection.
module irq_ctrl_wb
  import irq_ctrl_wb_pkg::*;
#(
  parameter int unsigned N_SRC = 8
) (
  input  logic             clk,
  input  logic             rst,
  irq_ctrl_wb_if.slave     bus,
  input  logic [N_SRC-1:0] ev_in,
  output logic             irq
);

  // Registers are kept 32 wide; bits at or above N_SRC are forced to 0 and trimmed by synthesis.
  localparam logic [31:0] SrcMask = 32'hFFFF_FFFF >> (32 - N_SRC);

  logic        r_ack;
  logic [31:0] r_rdata;
  logic        r_wr_stb;
  logic [2:0]  r_wr_addr;
  logic [31:0] r_wr_data;
  logic [31:0] r_ev_q;
  logic [31:0] r_enable;
  logic [31:0] r_pending;
  logic        r_irq;

  logic [31:0]               w_ev_in;
  logic [31:0]               w_rdata;
  logic [31:0]               w_enable_d;
  logic [31:0]               w_pending_d;
  logic [31:0]               w_clr;
  logic [31:0]               w_set;
  logic [31:0]               w_active;
  logic                      w_claim_valid;
  logic [IRQ_CLAIM_ID_W-1:0] w_claim_id;

  assign w_ev_in      = 32'(ev_in);
  assign w_active     = r_pending & r_enable;
  assign bus.wb_ack   = r_ack;
  assign bus.wb_rdata = r_rdata;
  assign irq          = r_irq;

  irq_prio_enc #(
    .N_SRC (N_SRC)
  ) u_prio_enc (
    .i_req   (w_active[N_SRC-1:0]),
    .o_valid (w_claim_valid),
    .o_id    (w_claim_id)
  );

`ifdef IRQ_CTRL_EDGE_MODE_EN
  logic [31:0] r_ev_d;
  logic [31:0] r_mode;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ev_d <= '0;
      r_mode <= '0;
    end else begin
      r_ev_d <= r_ev_q;
      if (r_wr_stb && (r_wr_addr == IRQ_REG_MODE)) begin
        r_mode <= r_wr_data & SrcMask;
      end
    end
  end

  assign w_set = (r_ev_q & ~r_mode) | (r_ev_q & ~r_ev_d & r_mode);
`else
  assign w_set = r_ev_q;
`endif

  always_comb begin
    w_rdata = '0;
    case (bus.wb_addr)
      IRQ_REG_STATUS:  w_rdata = r_ev_q;
      IRQ_REG_ENABLE:  w_rdata = r_enable;
      IRQ_REG_PENDING: w_rdata = r_pending;
      IRQ_REG_CLAIM:   w_rdata = pack_claim(w_claim_valid, w_claim_id);
`ifdef IRQ_CTRL_EDGE_MODE_EN
      IRQ_REG_MODE:    w_rdata = r_mode;
`else
      IRQ_REG_MODE:    w_rdata = '0;
`endif
      default:         w_rdata = '0;
    endcase
  end

  // A set condition in the same cycle as a W1C wins.
  always_comb begin
    w_enable_d = r_enable;
    w_clr      = '0;
    if (r_wr_stb && (r_wr_addr == IRQ_REG_ENABLE)) begin
      w_enable_d = r_wr_data & SrcMask;
    end
    if (r_wr_stb && (r_wr_addr == IRQ_REG_PENDING)) begin
      w_clr = r_wr_data;
    end
    w_pending_d = ((r_pending & ~w_clr) | w_set) & SrcMask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack     <= 1'b0;
      r_rdata   <= '0;
      r_wr_stb  <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_ev_q    <= '0;
      r_enable  <= '0;
      r_pending <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_ack     <= bus.wb_cyc & ~r_ack;
      r_rdata   <= (bus.wb_cyc && !r_ack) ? w_rdata : '0;
      r_wr_stb  <= bus.wb_cyc & bus.wb_we & ~r_ack;
      r_wr_addr <= bus.wb_addr;
      r_wr_data <= bus.wb_wdata;
      r_ev_q    <= w_ev_in;
      r_enable  <= w_enable_d;
      r_pending <= w_pending_d;
      r_irq     <= |w_active;
    end
  end

endmodule
